// File: rtl/fetch_sequencer_pkg.sv
// Shared Y86 fetch definitions: instruction codes, status codes, fetch states
// and the default datapath width.
package fetch_sequencer_pkg;

   localparam int DATA_WID_DEFAULT = 32;

   // Y86 instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Processor status codes
   localparam logic [1:0] SAOK = 2'd0;
   localparam logic [1:0] SHLT = 2'd1;
   localparam logic [1:0] SINS = 2'd2;
   localparam logic [1:0] SADR = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_RET_WAIT = 2'd1,
      ST_HALTED   = 2'd2,
      ST_ERROR    = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_instr_len.sv
// Combinational Y86 instruction length decoder. Shared with the decode-side
// checker so both stages agree on instruction sizes.
module fetch_sequencer_instr_len
   import fetch_sequencer_pkg::*;
#(
   parameter int DATA_WID = DATA_WID_DEFAULT
) (
   input  logic [3:0]          icode,
   output logic [DATA_WID-1:0] len,
   output logic                invalid
);

   localparam int VALC_BYTES = DATA_WID / 8;

   // Map icode to byte length; unknown codes are flagged and treated as one byte
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      len     = DATA_WID'(1);
      invalid = 1'b0;
      case (icode)
         IHALT, INOP, IRET:              len = DATA_WID'(1);
         IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:   len = DATA_WID'(2);
         IJXX, ICALL:                    len = DATA_WID'(1 + VALC_BYTES);
         IIRMOVQ, IRMMOVQ, IMRMOVQ:      len = DATA_WID'(2 + VALC_BYTES);
         default:                        invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Y86 fetch-stage controller: owns the PC, reads the combinational
// instruction memory, predicts the next PC and hands one instruction per
// valid/ready handshake to decode. Redirects from execute override everything.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                  DATA_WID = DATA_WID_DEFAULT,
   parameter logic [DATA_WID-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic [DATA_WID-1:0] imem_pc,
   input  logic [3:0]          imem_icode,
   input  logic [3:0]          imem_ifun,
   input  logic [3:0]          imem_rA,
   input  logic [3:0]          imem_rB,
   input  logic [DATA_WID-1:0] imem_valC,
   input  logic                imem_error,
   input  logic                redirect_valid,
   input  logic [DATA_WID-1:0] redirect_pc,
   output logic                f_valid,
   input  logic                f_ready,
   output logic [3:0]          f_icode,
   output logic [3:0]          f_ifun,
   output logic [3:0]          f_rA,
   output logic [3:0]          f_rB,
   output logic [DATA_WID-1:0] f_valC,
   output logic [DATA_WID-1:0] f_pc,
   output logic [DATA_WID-1:0] f_valP,
   output logic [1:0]          stat
);

   fetch_state_e        state_q, state_d;
   logic [DATA_WID-1:0] pc_q, pc_d;
   logic [1:0]          stat_q, stat_d;
   logic                f_valid_q, f_valid_d;
   logic [3:0]          f_icode_q, f_icode_d;
   logic [3:0]          f_ifun_q, f_ifun_d;
   logic [3:0]          f_ra_q, f_ra_d;
   logic [3:0]          f_rb_q, f_rb_d;
   logic [DATA_WID-1:0] f_valc_q, f_valc_d;
   logic [DATA_WID-1:0] f_pc_q, f_pc_d;
   logic [DATA_WID-1:0] f_valp_q, f_valp_d;

   logic [DATA_WID-1:0] len;
   logic                invalid;
   logic [DATA_WID-1:0] val_p;
   logic                load;

   fetch_sequencer_instr_len #(.DATA_WID(DATA_WID)) u_instr_len (
      .icode   (imem_icode),
      .len     (len),
      .invalid (invalid)
   );

   // Fall-through address wraps silently at 2^DATA_WID
   assign val_p   = pc_q + len;
   assign imem_pc = pc_q;
   assign load    = (state_q == ST_RUN) && (!f_valid_q || f_ready) && !redirect_valid;

   // Next-state, next-PC and fetch-register update
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      stat_d    = stat_q;
      f_valid_d = f_valid_q;
      f_icode_d = f_icode_q;
      f_ifun_d  = f_ifun_q;
      f_ra_d    = f_ra_q;
      f_rb_d    = f_rb_q;
      f_valc_d  = f_valc_q;
      f_pc_d    = f_pc_q;
      f_valp_d  = f_valp_q;

      if (redirect_valid) begin
         // Any pending handshake this cycle still completes; the slot is then squashed
         pc_d      = redirect_pc;
         f_valid_d = 1'b0;
         state_d   = ST_RUN;
         stat_d    = SAOK;
      end else if (load) begin
         f_icode_d = imem_icode;
         f_ifun_d  = imem_ifun;
         f_ra_d    = imem_rA;
         f_rb_d    = imem_rB;
         f_valc_d  = imem_valC;
         f_pc_d    = pc_q;
         f_valp_d  = val_p;
         f_valid_d = 1'b1;
         if (imem_error) begin
            state_d = ST_ERROR;
            stat_d  = SADR;
         end else if (invalid) begin
            state_d = ST_ERROR;
            stat_d  = SINS;
         end else begin
            case (imem_icode)
               IHALT: begin
                  state_d = ST_HALTED;
                  stat_d  = SHLT;
               end
               IRET:        state_d = ST_RET_WAIT;
               IJXX, ICALL: pc_d    = imem_valC;
               default:     pc_d    = val_p;
            endcase
         end
      end else if (f_ready && f_valid_q) begin
         f_valid_d = 1'b0;
      end
   end

   // State, PC and fetch register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_PC;
         stat_q    <= SAOK;
         f_valid_q <= 1'b0;
         f_icode_q <= '0;
         f_ifun_q  <= '0;
         f_ra_q    <= '0;
         f_rb_q    <= '0;
         f_valc_q  <= '0;
         f_pc_q    <= '0;
         f_valp_q  <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q   <= state_d;
         pc_q      <= pc_d;
         stat_q    <= stat_d;
         f_valid_q <= f_valid_d;
         f_icode_q <= f_icode_d;
         f_ifun_q  <= f_ifun_d;
         f_ra_q    <= f_ra_d;
         f_rb_q    <= f_rb_d;
         f_valc_q  <= f_valc_d;
         f_pc_q    <= f_pc_d;
         f_valp_q  <= f_valp_d;
      end
   end

   assign f_valid = f_valid_q;
   assign f_icode = f_icode_q;
   assign f_ifun  = f_ifun_q;
   assign f_rA    = f_ra_q;
   assign f_rB    = f_rb_q;
   assign f_valC  = f_valc_q;
   assign f_pc    = f_pc_q;
   assign f_valP  = f_valp_q;
   assign stat    = stat_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-walking reference model
// predicts the delivered instruction stream; a negedge monitor compares.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] imem_pc;
   logic [3:0]    imem_icode, imem_ifun, imem_rA, imem_rB;
   logic [DW-1:0] imem_valC;
   logic          imem_error;
   logic          redirect_valid;
   logic [DW-1:0] redirect_pc;
   logic          f_valid, f_ready;
   logic [3:0]    f_icode, f_ifun, f_rA, f_rB;
   logic [DW-1:0] f_valC, f_pc, f_valP;
   logic [1:0]    stat;

   fetch_sequencer #(.DATA_WID(DW), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst), .imem_pc(imem_pc),
      .imem_icode(imem_icode), .imem_ifun(imem_ifun), .imem_rA(imem_rA),
      .imem_rB(imem_rB), .imem_valC(imem_valC), .imem_error(imem_error),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .f_valid(f_valid), .f_ready(f_ready), .f_icode(f_icode), .f_ifun(f_ifun),
      .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_pc(f_pc), .f_valP(f_valP),
      .stat(stat)
   );

   always #5 clk = ~clk;

   // Instruction memory: 256 entries aliased over the address space; the
   // 0x....EExx window reports an address error.
   logic [3:0]    m_icode[256];
   logic [3:0]    m_ifun[256];
   logic [3:0]    m_ra[256];
   logic [3:0]    m_rb[256];
   logic [DW-1:0] m_valc[256];

   assign imem_icode = m_icode[imem_pc[7:0]];
   assign imem_ifun  = m_ifun[imem_pc[7:0]];
   assign imem_rA    = m_ra[imem_pc[7:0]];
   assign imem_rB    = m_rb[imem_pc[7:0]];
   assign imem_valC  = m_valc[imem_pc[7:0]];
   assign imem_error = (imem_pc[15:8] == 8'hEE);

   typedef struct packed {
      logic [3:0]    icode, ifun, ra, rb;
      logic [DW-1:0] valc, pc, valp;
      logic [1:0]    stat;
   } item_t;

   item_t         exp_q[$];
   logic [DW-1:0] walk_pc;
   bit            walk_stop;
   int            checks = 0;
   int            errors = 0;
   int            handshakes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Instruction byte length from the Y86 encoding rules
   function automatic int unsigned ref_len(input logic [3:0] ic);
      if (ic == 4'h0 || ic == 4'h1 || ic == 4'h9) return 1;
      if (ic == 4'h2 || ic == 4'h6 || ic == 4'hA || ic == 4'hB) return 2;
      if (ic == 4'h7 || ic == 4'h8) return 1 + DW / 8;
      if (ic >= 4'h3 && ic <= 4'h5) return 2 + DW / 8;
      return 1;
   endfunction

   // Walk the program one instruction and queue what decode should receive
   task automatic model_push();
      item_t it;
      bit    adr;
      it.icode = m_icode[walk_pc[7:0]];
      it.ifun  = m_ifun[walk_pc[7:0]];
      it.ra    = m_ra[walk_pc[7:0]];
      it.rb    = m_rb[walk_pc[7:0]];
      it.valc  = m_valc[walk_pc[7:0]];
      it.pc    = walk_pc;
      it.valp  = DW'(walk_pc + ref_len(it.icode));
      adr      = (walk_pc[15:8] == 8'hEE);
      if (adr)                   it.stat = 2'd3;
      else if (it.icode > 4'hB)  it.stat = 2'd2;
      else if (it.icode == 4'h0) it.stat = 2'd1;
      else                       it.stat = 2'd0;
      exp_q.push_back(it);
      if (adr || it.icode > 4'hB || it.icode == 4'h0 || it.icode == 4'h9) walk_stop = 1'b1;
      else if (it.icode == 4'h7 || it.icode == 4'h8) walk_pc = it.valc;
      else walk_pc = it.valp;
   endtask

   // Monitor: compare the presented instruction, retire on handshake, restart on redirect
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         walk_pc   = '0;
         walk_stop = 1'b0;
      end else begin
         if (f_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected actual pc=%0h required=no instruction", f_pc);
            end else begin
               check("sb_fields", {f_icode, f_ifun, f_rA, f_rB, stat},
                     {exp_q[0].icode, exp_q[0].ifun, exp_q[0].ra, exp_q[0].rb, exp_q[0].stat});
               check("sb_valC", f_valC, exp_q[0].valc);
               check("sb_pc",   f_pc,   exp_q[0].pc);
               check("sb_valP", f_valP, exp_q[0].valp);
               if (f_ready) begin
                  void'(exp_q.pop_front());
                  handshakes++;
               end
            end
         end
         if (redirect_valid) begin
            exp_q.delete();
            walk_pc   = redirect_pc;
            walk_stop = 1'b0;
         end
      end
      while (!walk_stop && exp_q.size() < 4) model_push();
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [DW-1:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic set_mem(input int a, input logic [3:0] ic, input logic [DW-1:0] vc);
      m_icode[a] = ic;
      m_ifun[a]  = 4'h0;
      m_ra[a]    = 4'h3;
      m_rb[a]    = 4'h5;
      m_valc[a]  = vc;
   endtask

   task automatic randomize_mem();
      for (int a = 0; a < 256; a++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r < 3)       m_icode[a] = IHALT;
         else if (r < 6)  m_icode[a] = 4'($urandom_range(12, 15));
         else if (r < 12) m_icode[a] = IRET;
         else if (r < 24) m_icode[a] = ($urandom_range(0, 1) == 0) ? IJXX : ICALL;
         else begin
            logic [3:0] pick[8];
            pick = '{INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
            m_icode[a] = pick[$urandom_range(0, 7)];
         end
         m_ifun[a] = 4'($urandom_range(0, 15));
         m_ra[a]   = 4'($urandom_range(0, 15));
         m_rb[a]   = 4'($urandom_range(0, 15));
         m_valc[a] = ($urandom_range(0, 19) == 0) ? (32'h0000_EE00 | 32'($urandom_range(0, 255)))
                                                  : 32'($urandom_range(0, 255));
      end
   endtask

   initial begin
      rst            = 1'b1;
      f_ready        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      for (int a = 0; a < 256; a++) set_mem(a, INOP, 32'h0);
      set_mem(8'h00, IIRMOVQ, 32'h1234);
      set_mem(8'h07, IJXX,    32'h10);
      set_mem(8'h10, IJXX,    32'h40);
      set_mem(8'h20, IRET,    32'h0);
      set_mem(8'h30, IHALT,   32'h0);
      set_mem(8'h31, 4'hC,    32'h0);
      set_mem(8'h32, 4'hD,    32'h0);
      set_mem(8'h81, IIRMOVQ, 32'h55);
      set_mem(8'hFE, IIRMOVQ, 32'h77);

      step();
      step();
      check("rst_f_valid", f_valid, 0);
      check("rst_stat", stat, SAOK);
      check("rst_imem_pc", imem_pc, 0);
      check("rst_fields", {f_icode, f_ifun, f_rA, f_rB, f_valC, f_pc, f_valP}, 0);

      // Straight line and predicted-taken jumps
      f_ready = 1'b1;
      rst     = 1'b0;
      step();
      check("irmov_f_pc", f_pc, 0);
      check("irmov_f_valP", f_valP, 6);
      check("irmov_next_pc", imem_pc, 6);
      step();
      check("nop_f_valP", f_valP, 7);
      check("nop_next_pc", imem_pc, 7);
      step();
      step();
      check("jxx_f_valP", f_valP, 32'h15);
      check("jxx_predict", imem_pc, 32'h40);
      redirect(32'h15);
      check("redir_squash", f_valid, 0);
      check("redir_pc", imem_pc, 32'h15);

      // ret parks until redirected
      redirect(32'h20);
      step();
      check("ret_loaded", f_valid, 1);
      step();
      check("ret_drop", f_valid, 0);
      step();
      step();
      check("ret_hold_pc", imem_pc, 32'h20);
      check("ret_no_load", f_valid, 0);
      redirect(32'h80);
      check("ret_resume_pc", imem_pc, 32'h80);
      step();
      check("resume_f_pc", f_pc, 32'h80);

      // Backpressure holds register and PC
      f_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_f_pc", f_pc, 32'h80);
         check("bp_f_valid", f_valid, 1);
         check("bp_pc", imem_pc, 32'h81);
      end
      f_ready = 1'b1;
      step();
      check("bp_release_f_pc", f_pc, 32'h81);
      check("bp_release_valid", f_valid, 1);

      // halt, invalid, address error, and recovery
      redirect(32'h30);
      step();
      check("halt_stat", stat, SHLT);
      step();
      step();
      check("halt_parked_valid", f_valid, 0);
      check("halt_parked_pc", imem_pc, 32'h30);
      redirect(32'h31);
      check("halt_recover_stat", stat, SAOK);
      step();
      check("ins_stat", stat, SINS);
      step();
      check("ins_parked_pc", imem_pc, 32'h31);
      redirect(32'h0000_EE32);
      step();
      check("adr_over_ins_stat", stat, SADR);
      redirect(32'h0000_EE00);
      step();
      check("adr_stat", stat, SADR);
      redirect(32'hFFFF_FFFE);
      check("adr_recover_stat", stat, SAOK);
      step();
      check("wrap_f_pc", f_pc, 32'hFFFF_FFFE);
      check("wrap_f_valP", f_valP, 32'h4);

      // Asynchronous reset while parked in RET_WAIT holding an instruction
      f_ready = 1'b0;
      redirect(32'h20);
      step();
      check("pre_rst_valid", f_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", f_valid, 0);
      check("async_rst_pc", imem_pc, 0);
      check("async_rst_stat", stat, SAOK);
      check("async_rst_f_pc", f_pc, 0);
      step();
      rst = 1'b0;

      // Randomized traffic against the scoreboard
      randomize_mem();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      handshakes = 0;
      for (int c = 0; c < 4000; c++) begin
         int unsigned sel;
         f_ready        = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 99) < 8);
         sel            = $urandom_range(0, 9);
         if (sel < 7)       redirect_pc = 32'($urandom_range(0, 255));
         else if (sel == 7) redirect_pc = 32'h0000_EE00 | 32'($urandom_range(0, 255));
         else               redirect_pc = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
         step();
      end
      redirect_valid = 1'b0;
      checks++;
      if (handshakes < 200) begin
         errors++;
         $display("FAIL liveness actual=%0d handshakes required>=200", handshakes);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch-stage controller for the Y86 core.
- Owns the program counter and drives it into the combinational instruction memory, INSTRU_MEN.
- Captures the decoded fields, computes valP and predicts the next PC.
- Presents one instruction per handshake to decode. Handles ret stalls, halt/exception parking and redirects from execute.

Parameters:
- DATA_WID, 32, address/data width in bits; must be a multiple of 8; valC occupies DATA_WID/8 bytes.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_pc  out  DATA_WID  address to INSTRU_MEN.PC
- imem_icode  in  4  from instruction memory
- imem_ifun  in  4  from instruction memory
- imem_rA  in  4  from instruction memory
- imem_rB  in  4  from instruction memory
- imem_valC  in  DATA_WID  from instruction memory
- imem_error  in  1  address out of range
- redirect_valid  in  1  execute requests PC change (mispredict or ret target)
- redirect_pc  in  DATA_WID  new PC
- f_valid  out  1  fetch register holds an instruction
- f_ready  in  1  decode accepts this cycle
- f_icode  out  4  registered instruction field
- f_ifun  out  4  registered instruction field
- f_rA  out  4  registered instruction field
- f_rB  out  4  registered instruction field
- f_valC  out  DATA_WID  registered instruction field
- f_pc  out  DATA_WID  address of the registered instruction
- f_valP  out  DATA_WID  fall-through address of the registered instruction
- stat  out  2  0=AOK, 1=HLT, 2=INS, 3=ADR

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=RUN, f_valid=0, stat=AOK.
  - All f_* data outputs are 0.
- imem_pc = pc (combinational); memory read is same-cycle.
- Length by icode:
  - halt/nop/ret = 1.
  - rrmov/OPq/push/pop = 2.
  - jXX/call = 1+DATA_WID/8.
  - irmov/rmmov/mrmov = 2+DATA_WID/8.
  - icode > 0xB is invalid.
- valP = pc + length, modulo 2^DATA_WID (wrap allowed, no flag).
- Load condition: load = (state==RUN) && (!f_valid || f_ready) && !redirect_valid.
  - On load: f_* <= fields, f_pc <= pc, f_valP <= valP, f_valid <= 1.
  - Otherwise, if f_ready && f_valid: f_valid <= 0.
  - f_* are held stable while f_valid && !f_ready.
- Next PC on load:
  - jXX/call: valC (predict taken).
  - ret: hold pc, go to RET_WAIT.
  - halt: go to HALTED, stat=HLT; the halt is still delivered.
  - invalid icode: go to ERROR, stat=INS; the instruction is delivered.
  - imem_error: go to ERROR, stat=ADR; the instruction is delivered, ADR takes priority over INS.
  - All other icodes: valP.
- RET_WAIT, HALTED, ERROR: no loads; pc held.
- Redirect has highest priority, in any state:
  - pc <= redirect_pc, f_valid <= 0 (squash), state <= RUN, stat <= AOK.
  - Takes effect at the next edge; fetch from the new PC begins the cycle after.
  - A wrong-path halt or fault is therefore recoverable.
- Redirect coinciding with a pending f_ready handshake: the handshake completes, then the register is squashed; decode must not count the squashed slot.
- Reset asserted mid-operation: immediate return to reset values, regardless of state or handshake.
- State encoding: RUN=0, RET_WAIT=1, HALTED=2, ERROR=3 (2 bits).

Decomposition:
- Shared header gets:
  - icode constants IHALT..IPOPQ.
  - stat codes SAOK/SHLT/SINS/SADR.
  - fetch state encodings.
  - DATA_WID default.
- One sub-module, instr_len: combinational icode -> length plus invalid flag, reused by the decode-side checker.
- The sequencer keeps the PC, FSM and fetch register.

Test Plan:
- Straight line, DATA_WID=32, f_ready=1: irmovl at 0 -> f_pc=0, f_valP=6; next imem_pc=6; nop at 6 -> f_valP=7.
- jXX at 0x10 with valC=0x40 -> f_valP=0x15; next imem_pc=0x40. Then redirect_valid=1, redirect_pc=0x15 -> f_valid=0 next cycle, imem_pc=0x15.
- ret at 0x20 -> state RET_WAIT, f_valid drops after handoff, imem_pc stays 0x20. redirect_pc=0x80 -> RUN, fetch at 0x80.
- Backpressure: f_ready=0 for 3 cycles with f_valid=1 -> f_* and pc unchanged; f_ready=1 -> next instruction loads the same cycle it is consumed.
- halt at 0x30 -> delivered once, stat=HLT, no further loads. Invalid icode 0xC -> stat=INS. imem_error=1 -> stat=ADR. Redirect in any of these -> RUN, stat=AOK.
- Assert rst during RET_WAIT with f_valid=1 -> outputs return to reset values asynchronously, imem_pc=RESET_PC.
